uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer directly downstream of `rx_core`. Captures each completed byte (and its parity-error status) announced by `rx_core` and stores it in a first-word-fall-through FIFO. Consumers drain bytes through a valid/ready handshake. Full-FIFO overflow is recorded in a sticky flag so that no loss is silent.

## Interface
Parameters:
- `DEPTH`, 16. Number of entries; must be a power of two and at least 2.
- `ADDR_W`, $clog2(DEPTH). Derived localparam; not overridable.

Ports:
- `clk`  in  1  system clock (100 MHz); one clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `data_rx`  in  8  received byte from `rx_core`; valid while `rec_data` or `err_data` is high.
- `rec_data`  in  1  byte received with good parity (level or pulse).
- `err_data`  in  1  byte received with bad parity (level or pulse).
- `rd_data`  out  8  byte at the FIFO head.
- `rd_err`  out  1  parity-error flag of the head entry.
- `rd_valid`  out  1  head entry is present (FIFO not empty).
- `rd_ready`  in  1  consumer accepts the head entry.
- `count`  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky: at least one byte was dropped because the FIFO was full.
- `clr_ovf`  in  1  clears `overflow`.

## Operation
- Capture event: rising edge of `(rec_data | err_data)`, detected against a registered copy of that OR.
  - A level held high for several cycles produces exactly one capture.
  - The copy register resets to 0.
- Entry content on capture: `{err, data}`.
  - `err = err_data` in the capture cycle. If both strobes are high, `err` is 1.
  - `data = data_rx` in the capture cycle.
- Push:
  - Accepted when not full, or when full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set.
- Pop: occurs on a clock edge where `rd_valid && rd_ready`. `rd_ready` while empty has no effect.
- Pointer and count rules:
  - Write and read pointers are ADDR_W bits and wrap modulo DEPTH.
  - `count` is +1 on push only, -1 on pop only, and unchanged on push+pop or on neither.
- Overflow flag:
  - `overflow` is set on a drop and cleared by `clr_ovf`.
  - If set and clear happen in the same cycle, set wins.
- Outputs:
  - `rd_valid = (count != 0)`.
  - `rd_data` and `rd_err` are read combinationally from the head entry.
  - `rd_data` and `rd_err` are don't-care while `rd_valid` is low; the bench must not check them then.

## Timing
- Reset values: `rd_valid` 0, `count` 0, `full` 0, `overflow` 0, both pointers 0, edge register 0. Storage contents are not reset.
- Write latency: if the capture edge is sampled at clock edge N, then `rd_valid`, `rd_data` and `rd_err` reflect the entry after edge N, i.e. 1 cycle.
- Pop latency: the next entry, or `rd_valid` low, is presented after the popping edge.
- Push and pop in the same cycle on an empty FIFO: only the push happens; `count` becomes 1.
- Push and pop in the same cycle on a full FIFO: both happen; `count` stays DEPTH and no overflow occurs.
- Reset asserted mid-operation: all state returns immediately to reset values and all stored entries are lost.
- A strobe still high when reset is released is captured once on the first active edge. This is accepted behaviour.

## Configuration
- `UART_RX_FIFO_DROP_ERR_EN`
  - Defined: captures with `err = 1` are discarded and never stored; `rd_err` is tied to 0. They do not set `overflow`.
  - Undefined: error bytes are stored and flagged through `rd_err`, as described above.

## Structure
- Shared package `uart_pkg`:
  - `rx_entry_t` packed struct `{logic err; logic [7:0] data;}`.
  - `CLK_FREQ_HZ = 100_000_000`, `BAUD = 19200`, `BIT_CYCLES = 5208` (used by `rx_core` and the benches).
- One sub-module, `uart_fifo_mem`:
  - DEPTH x `rx_entry_t` storage.
  - Synchronous write port and asynchronous read port.
  - No reset.
  - Pointer, count and flag logic stays in `uart_rx_fifo`.

## Test plan
- Single byte: `data_rx = 8'hA5`, `rec_data` high for 3 cycles. Required: exactly one entry, `rd_valid` 1 cycle later, `rd_data = A5`, `rd_err = 0`, `count = 1`. Pop gives `count = 0` and `rd_valid = 0`.
- Error byte: `err_data` pulse with `data_rx = 8'h3C`.
  - Macro undefined: `rd_err = 1`, `rd_data = 3C`.
  - Macro defined: `count` stays 0.
- Fill and overflow: 17 captures of 00..10 with DEPTH = 16 and `rd_ready = 0`. Required: `full = 1`, `count = 16`, `overflow = 1`. Draining yields 00..0F in order; 10 is lost.
- Simultaneous push and pop when full: capture 8'h55 in the same cycle as a pop. Required: `count` stays 16, `overflow` is not set, and 55 appears as the last entry.
- Overflow clear priority: `clr_ovf` asserted in the same cycle as a drop leaves `overflow = 1`; `clr_ovf` alone clears it.
- Reset mid-fill: assert `rst_n = 0` with 5 entries stored. Required: `count = 0`, `rd_valid = 0`, `overflow = 0` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FIFO entry format and baud timing constants.
// Used by rx_core, uart_rx_fifo and the benches.
package uart_pkg;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rx_entry_t;

    localparam int ENTRY_W     = $bits(rx_entry_t);
    localparam int CLK_FREQ_HZ = 100_000_000;
    localparam int BAUD        = 19200;
    localparam int BIT_CYCLES  = 5208;

endpackage

// File: rtl/uart_fifo_mem.sv
// Receive FIFO storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [ENTRY_W-1:0] rdata
);

    rx_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= rx_entry_t'(wdata);
        end
    end

    assign rdata = ENTRY_W'(mem[raddr]);

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through buffer for bytes announced by rx_core.
// Define UART_RX_FIFO_DROP_ERR_EN to discard parity-error bytes instead of storing them.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      data_rx,
    input  logic            rec_data,
    input  logic            err_data,
    output logic [7:0]      rd_data,
    output logic            rd_err,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            overflow,
    input  logic            clr_ovf
);

    logic              strobe;
    logic              strobe_q;
    logic              cap;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              drop;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    rx_entry_t         wr_entry;
    rx_entry_t         head;
    logic [ENTRY_W-1:0] head_raw;

    // One capture per rising edge of either strobe, so held levels count once
    assign strobe = rec_data | err_data;
    assign cap    = strobe & ~strobe_q;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign push_req = cap & ~err_data;
`else
    assign push_req = cap;
`endif

    assign wr_entry = '{err: err_data, data: data_rx};

    assign rd_valid = (count != '0);
    assign full     = (count == (ADDR_W+1)'(DEPTH));
    assign pop      = rd_valid & rd_ready;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (ADDR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (ADDR_W+1)'(1);
            end
        end
    end

    // A drop in the same cycle as a clear must still be reported
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (ENTRY_W'(wr_entry)),
        .raddr (rd_ptr),
        .rdata (head_raw)
    );

    assign head    = rx_entry_t'(head_raw);
    assign rd_data = head.data;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign rd_err = 1'b0;
`else
    assign rd_err = head.err;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH = 16).
// Honours UART_RX_FIFO_DROP_ERR_EN for the error-byte step.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_rx;
    logic       rec_data;
    logic       err_data;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       clr_ovf;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_rx  (data_rx),
        .rec_data (rec_data),
        .err_data (err_data),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [7:0] d, input logic e);
        data_rx  = d;
        rec_data = ~e;
        err_data = e;
        tick();
        rec_data = 1'b0;
        err_data = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        data_rx  = 8'h00;
        rec_data = 1'b0;
        err_data = 1'b0;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single byte with a 3-cycle level strobe
        data_rx  = 8'hA5;
        rec_data = 1'b1;
        tick();
        check("one_valid", 32'(rd_valid), 32'd1);
        check("one_data", 32'(rd_data), 32'hA5);
        check("one_err", 32'(rd_err), 32'd0);
        check("one_count", 32'(count), 32'd1);
        tick();
        tick();
        rec_data = 1'b0;
        tick();
        check("level_once", 32'(count), 32'd1);
        pop_one();
        check("one_pop_cnt", 32'(count), 32'd0);
        check("one_pop_vld", 32'(rd_valid), 32'd0);
        pop_one();
        check("empty_pop", 32'(count), 32'd0);

        // Parity-error byte
        cap(8'h3C, 1'b1);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        check("errdrop_cnt", 32'(count), 32'd0);
        check("errdrop_ovf", 32'(overflow), 32'd0);
`else
        check("err_valid", 32'(rd_valid), 32'd1);
        check("err_flag", 32'(rd_err), 32'd1);
        check("err_data", 32'(rd_data), 32'h3C);
        pop_one();
        check("err_pop", 32'(count), 32'd0);
`endif

        // Fill past capacity with the pointers away from zero
        for (int i = 0; i <= 16; i++) begin
            cap(8'(i), 1'b0);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        check("fill_ovf", 32'(overflow), 32'd1);

        // Clear collides with another drop
        data_rx  = 8'h77;
        rec_data = 1'b1;
        clr_ovf  = 1'b1;
        tick();
        rec_data = 1'b0;
        clr_ovf  = 1'b0;
        tick();
        check("clr_prio", 32'(overflow), 32'd1);
        check("clr_prio_cnt", 32'(count), 32'd16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_alone", 32'(overflow), 32'd0);

        // Push and pop together while full
        check("pp_head", 32'(rd_data), 32'h00);
        data_rx  = 8'h55;
        rec_data = 1'b1;
        rd_ready = 1'b1;
        tick();
        rec_data = 1'b0;
        rd_ready = 1'b0;
        tick();
        check("pp_count", 32'(count), 32'd16);
        check("pp_ovf", 32'(overflow), 32'd0);

        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
            pop_one();
        end
        check("drain_last", 32'(rd_data), 32'h55);
        pop_one();
        check("drain_cnt", 32'(count), 32'd0);
        check("drain_vld", 32'(rd_valid), 32'd0);

        // Reset with 5 entries held and overflow set
        for (int i = 0; i <= 16; i++) begin
            cap(8'(8'h80 + i), 1'b0);
        end
        rd_ready = 1'b1;
        repeat (11) tick();
        rd_ready = 1'b0;
        check("mid_count", 32'(count), 32'd5);
        check("mid_ovf", 32'(overflow), 32'd1);
        check("mid_head", 32'(rd_data), 32'h8B);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(rd_valid), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        cap(8'hC3, 1'b0);
        check("post_count", 32'(count), 32'd1);
        check("post_data", 32'(rd_data), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
